// File: rtl/led_pkg.sv
// Shared constants and helpers for the trailing-fade LED driver.
package led_pkg;

  localparam int LED_NUM = 4;
  localparam int DUTY_W  = 8;

  localparam logic [DUTY_W-1:0]  DUTY_FULL = 8'hFF;
  // LEDs are active-low, so all-ones means every LED is dark.
  localparam logic [LED_NUM-1:0] LED_OFF   = 4'b1111;

  // Saturating decrement: a duty never wraps below zero.
  function automatic logic [DUTY_W-1:0] duty_decay(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] step
  );
    return (duty > step) ? (duty - step) : '0;
  endfunction

endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: duty register with priority update, PWM compare, output flop.
module led_pwm_ch
  import led_pkg::*;
#(
  parameter logic [DUTY_W-1:0] DECAY_STEP = 8'd1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ch_active,
  input  logic              en,
  input  logic              fade_tick,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic              led_out
);

  logic [DUTY_W-1:0] duty;
  logic              lit;

  // Full duty is forced lit so an active LED never shows a one-count gap.
  assign lit = (duty == DUTY_FULL) || (pwm_cnt < duty);

  // Duty update: reactivation wins over everything, including a same-cycle tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      duty <= '0;
    end else if (ch_active) begin
      duty <= DUTY_FULL;
    end else if (!en) begin
      duty <= '0;
    end else if (fade_tick) begin
      duty <= duty_decay(duty, DECAY_STEP);
    end
  end

  // Registered active-low output.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_out <= 1'b1;
    end else begin
      led_out <= ~lit;
    end
  end

endmodule

// File: rtl/led_fade.sv
// Trailing-fade LED driver: input registers, shared PWM and fade-tick counters,
// one led_pwm_ch per LED.
module led_fade
  import led_pkg::*;
#(
  parameter logic [23:0]       FADE_TICK_MAX = 24'd195311,
  parameter logic [DUTY_W-1:0] DECAY_STEP    = 8'd1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [LED_NUM-1:0] led_in,
  input  logic               fade_en,
  output logic [LED_NUM-1:0] led_out
);

  logic [LED_NUM-1:0] in_reg;
  logic               en_reg;
  logic [DUTY_W-1:0]  pwm_cnt;
  logic [23:0]        tick_cnt;
  logic               fade_tick;

  // Register the upstream pattern and enable once; same clock domain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_reg <= LED_OFF;
      en_reg <= 1'b0;
    end else begin
      in_reg <= led_in;
      en_reg <= fade_en;
    end
  end

  // Free-running 256-cycle PWM frame counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Fade tick period counter, wraps after FADE_TICK_MAX.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == FADE_TICK_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 24'd1;
    end
  end

  assign fade_tick = (tick_cnt == FADE_TICK_MAX);

  for (genvar i = 0; i < LED_NUM; i++) begin : gen_ch
    led_pwm_ch #(
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .ch_active(~in_reg[i]),
      .en       (en_reg),
      .fade_tick(fade_tick),
      .pwm_cnt  (pwm_cnt),
      .led_out  (led_out[i])
    );
  end

endmodule
